// File: rtl/cnn_mac_pool_engine.sv
// Multi-beat MAC over N_FILT filters followed by max/average pooling of the
// filter results, with a saturated result presented on a valid/ready port.
module cnn_mac_pool_engine #(
  parameter int DATA_W = 8,
  parameter int N_IN   = 16,
  parameter int LANES  = 4,
  parameter int N_FILT = 4,
  parameter int ACC_W  = 2*DATA_W + $clog2(N_IN),
  parameter int OUT_W  = 16
) (
  input  logic                             Clk,
  input  logic                             Rst,
  input  logic                             In_Valid,
  output logic                             In_Ready,
  input  logic [LANES*DATA_W-1:0]          In_Data,
  input  logic [N_FILT*LANES*DATA_W-1:0]   W_Data,
  input  logic                             Mode,
  output logic                             Out_Valid,
  input  logic                             Out_Ready,
  output logic [OUT_W-1:0]                 Out_Data,
  output logic [$clog2(N_FILT)-1:0]        Out_Idx,
  output logic                             Out_Sat
);

  localparam int BEATS = N_IN / LANES;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int FW    = $clog2(N_FILT);
  localparam int SUM_W = ACC_W + FW;

  typedef enum logic [1:0] {ST_ACC, ST_POOL, ST_OUT} state_t;

  state_t            state_q, state_d;
  logic [BW-1:0]     beat_q, beat_d;
  logic              mode_q, mode_d;
  logic [ACC_W-1:0]  acc_q [N_FILT];
  logic [ACC_W-1:0]  acc_d [N_FILT];
  logic [ACC_W-1:0]  beat_sum [N_FILT];
  logic [OUT_W-1:0]  data_q, data_d;
  logic [FW-1:0]     idx_q, idx_d;
  logic              sat_q, sat_d;

  logic [ACC_W-1:0]  max_val;
  logic [FW-1:0]     max_idx;
  logic [SUM_W-1:0]  sum_all;
  logic [SUM_W-1:0]  pool_val;
  logic [OUT_W-1:0]  pool_data;
  logic              pool_sat;

  // Operands are widened before multiplying so the product is not truncated.
  always_comb begin
    for (int f = 0; f < N_FILT; f++) begin
      beat_sum[f] = '0;
      for (int k = 0; k < LANES; k++) begin
        beat_sum[f] = beat_sum[f]
          + ACC_W'(In_Data[k*DATA_W +: DATA_W]) * ACC_W'(W_Data[(f*LANES+k)*DATA_W +: DATA_W]);
      end
    end
  end

  // Strict comparison keeps the lowest index on ties.
  always_comb begin
    max_val = acc_q[0];
    max_idx = '0;
    sum_all = '0;
    for (int f = 0; f < N_FILT; f++) begin
      sum_all = sum_all + SUM_W'(acc_q[f]);
      if (acc_q[f] > max_val) begin
        max_val = acc_q[f];
        max_idx = FW'(f);
      end
    end
    pool_val = mode_q ? (sum_all >> FW) : SUM_W'(max_val);
  end

  generate
    if (SUM_W > OUT_W) begin : g_sat
      assign pool_sat  = |pool_val[SUM_W-1:OUT_W];
      assign pool_data = pool_sat ? {OUT_W{1'b1}} : pool_val[OUT_W-1:0];
    end else begin : g_nosat
      assign pool_sat  = 1'b0;
      assign pool_data = OUT_W'(pool_val);
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    mode_d  = mode_q;
    acc_d   = acc_q;
    data_d  = data_q;
    idx_d   = idx_q;
    sat_d   = sat_q;
    case (state_q)
      ST_ACC: begin
        if (In_Valid) begin
          for (int f = 0; f < N_FILT; f++) acc_d[f] = acc_q[f] + beat_sum[f];
          if (beat_q == '0) mode_d = Mode;
          if (beat_q == BW'(BEATS-1)) begin
            beat_d  = '0;
            state_d = ST_POOL;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      ST_POOL: begin
        data_d  = pool_data;
        idx_d   = mode_q ? '0 : max_idx;
        sat_d   = pool_sat;
        state_d = ST_OUT;
      end
      ST_OUT: begin
        if (Out_Ready) begin
          for (int f = 0; f < N_FILT; f++) acc_d[f] = '0;
          mode_d  = 1'b0;
          state_d = ST_ACC;
        end
      end
      default: state_d = ST_ACC;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= ST_ACC;
      beat_q  <= '0;
      mode_q  <= 1'b0;
      data_q  <= '0;
      idx_q   <= '0;
      sat_q   <= 1'b0;
      for (int f = 0; f < N_FILT; f++) acc_q[f] <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      mode_q  <= mode_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      sat_q   <= sat_d;
      for (int f = 0; f < N_FILT; f++) acc_q[f] <= acc_d[f];
    end
  end

  assign In_Ready  = (state_q == ST_ACC);
  assign Out_Valid = (state_q == ST_OUT);
  assign Out_Data  = data_q;
  assign Out_Idx   = idx_q;
  assign Out_Sat   = sat_q;

endmodule

// File: tb/tb_cnn_mac_pool_engine.sv
// Directed bench for cnn_mac_pool_engine at default parameters (BEATS=4),
// with hand-computed pooled results.
module tb_cnn_mac_pool_engine;

  logic          Clk = 1'b0;
  logic          Rst;
  logic          In_Valid;
  logic          In_Ready;
  logic [31:0]   In_Data;
  logic [127:0]  W_Data;
  logic          Mode;
  logic          Out_Valid;
  logic          Out_Ready;
  logic [15:0]   Out_Data;
  logic [1:0]    Out_Idx;
  logic          Out_Sat;

  int checks = 0;
  int errors = 0;

  cnn_mac_pool_engine dut (
    .Clk(Clk), .Rst(Rst),
    .In_Valid(In_Valid), .In_Ready(In_Ready), .In_Data(In_Data), .W_Data(W_Data),
    .Mode(Mode),
    .Out_Valid(Out_Valid), .Out_Ready(Out_Ready), .Out_Data(Out_Data),
    .Out_Idx(Out_Idx), .Out_Sat(Out_Sat)
  );

  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // All lanes carry the same pixel; each filter uses one weight on all lanes.
  task automatic drive_beat(input logic [7:0] px, input logic [7:0] w0, input logic [7:0] w1,
                            input logic [7:0] w2, input logic [7:0] w3);
    In_Data = {4{px}};
    W_Data  = {{4{w3}}, {4{w2}}, {4{w1}}, {4{w0}}};
  endtask

  // pat bit i = In_Valid in step i; invalid steps carry random junk data.
  // mode0 drives Mode on the first accepted beat, mode_rest afterwards.
  task automatic window(input string tag, input int len, input logic [15:0] pat,
                        input logic [7:0] px, input logic [7:0] w0, input logic [7:0] w1,
                        input logic [7:0] w2, input logic [7:0] w3,
                        input logic mode0, input logic mode_rest,
                        input logic [15:0] exp_data, input logic [1:0] exp_idx, input logic exp_sat);
    bit first = 1'b1;
    for (int i = 0; i < len; i++) begin
      In_Valid = pat[i];
      if (pat[i]) begin
        drive_beat(px, w0, w1, w2, w3);
        Mode  = first ? mode0 : mode_rest;
        first = 1'b0;
      end else begin
        In_Data = $urandom;
        W_Data  = {$urandom, $urandom, $urandom, $urandom};
        Mode    = ~mode0;
      end
      step();
    end
    In_Valid = 1'b0;
    Mode     = ~mode0;
    check({tag, ".pool_in_ready"}, In_Ready, 0);
    check({tag, ".pool_out_valid"}, Out_Valid, 0);
    step();
    check({tag, ".out_valid"}, Out_Valid, 1);
    check({tag, ".out_in_ready"}, In_Ready, 0);
    check({tag, ".data"}, Out_Data, exp_data);
    check({tag, ".idx"}, Out_Idx, exp_idx);
    check({tag, ".sat"}, Out_Sat, exp_sat);
    $display("window %s: data=%0d idx=%0d sat=%0d", tag, Out_Data, Out_Idx, Out_Sat);
  endtask

  task automatic handshake(input string tag);
    Out_Ready = 1'b1;
    step();
    Out_Ready = 1'b0;
    check({tag, ".hs_out_valid"}, Out_Valid, 0);
    check({tag, ".hs_in_ready"}, In_Ready, 1);
  endtask

  initial begin
    Rst = 1'b1; In_Valid = 1'b0; In_Data = '0; W_Data = '0; Mode = 1'b0; Out_Ready = 1'b0;
    step(); step();
    Rst = 1'b0;
    step();
    check("rst.in_ready", In_Ready, 1);
    check("rst.out_valid", Out_Valid, 0);
    check("rst.data", Out_Data, 0);
    check("rst.idx", Out_Idx, 0);
    check("rst.sat", Out_Sat, 0);

    // Case 1: filter sums 16/32/48/64, max wins at index 3
    window("max_basic", 4, 16'hF, 8'd1, 8'd1, 8'd2, 8'd3, 8'd4, 1'b0, 1'b0, 16'd64, 2'd3, 1'b0);
    handshake("max_basic");

    // Case 2: average (16+32+48+64)/4 = 40; tie of 32s resolves to index 0
    window("avg_basic", 4, 16'hF, 8'd1, 8'd1, 8'd2, 8'd3, 8'd4, 1'b1, 1'b1, 16'd40, 2'd0, 1'b0);
    handshake("avg_basic");
    window("max_tie", 4, 16'hF, 8'd1, 8'd2, 8'd2, 8'd2, 8'd2, 1'b0, 1'b0, 16'd32, 2'd0, 1'b0);
    handshake("max_tie");

    // Case 3 + 4: 255*255*16 = 1040400 saturates; then hold under backpressure
    window("sat", 4, 16'hF, 8'd255, 8'd255, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 16'hFFFF, 2'd0, 1'b1);
    In_Valid = 1'b1;
    drive_beat(8'd7, 8'd9, 8'd9, 8'd9, 8'd9);
    for (int c = 0; c < 5; c++) begin
      step();
      check("bp.in_ready", In_Ready, 0);
      check("bp.out_valid", Out_Valid, 1);
      check("bp.data", Out_Data, 16'hFFFF);
      check("bp.sat", Out_Sat, 1);
    end
    In_Valid = 1'b0;
    handshake("bp");
    window("after_bp", 4, 16'hF, 8'd1, 8'd1, 8'd2, 8'd3, 8'd4, 1'b1, 1'b1, 16'd40, 2'd0, 1'b0);
    handshake("after_bp");

    // Case 5: bubbles 1,0,0,1,1,0,1 and Mode flipped after beat 0
    window("bubble_max", 7, 16'd89, 8'd1, 8'd1, 8'd2, 8'd3, 8'd4, 1'b0, 1'b1, 16'd64, 2'd3, 1'b0);
    handshake("bubble_max");
    window("bubble_avg", 7, 16'd89, 8'd1, 8'd1, 8'd2, 8'd3, 8'd4, 1'b1, 1'b0, 16'd40, 2'd0, 1'b0);
    handshake("bubble_avg");

    // Case 6: reset after two beats discards the partial window
    In_Valid = 1'b1;
    drive_beat(8'd200, 8'd200, 8'd200, 8'd200, 8'd200);
    Mode = 1'b1;
    step(); step();
    In_Valid = 1'b0;
    Rst = 1'b1;
    step();
    Rst = 1'b0;
    check("midrst.in_ready", In_Ready, 1);
    check("midrst.out_valid", Out_Valid, 0);
    check("midrst.data", Out_Data, 0);
    check("midrst.idx", Out_Idx, 0);
    check("midrst.sat", Out_Sat, 0);
    window("post_rst", 4, 16'hF, 8'd1, 8'd1, 8'd2, 8'd3, 8'd4, 1'b0, 1'b0, 16'd64, 2'd3, 1'b0);
    handshake("post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cnn_mac_pool_engine.md
# cnn_mac_pool_engine

Parametrised, handshake-driven successor to the fixed 16-input / 4-filter accelerator datapath. It streams a window of N_IN unsigned pixels and N_FILT weight sets through LANES parallel multipliers over several beats, accumulating one dot product per filter. It then reduces the filter results by max or average pooling and presents one saturated result on a valid/ready output port. It sits between the input/weight buffers and the output buffer of the accelerator top level.

## Interface

Parameters:
- DATA_W, 8, pixel and weight width (unsigned).
- N_IN, 16, pixels per window; must be a multiple of LANES.
- LANES, 4, pixels consumed per accepted beat; BEATS = N_IN/LANES.
- N_FILT, 4, filter count; power of two, ≥2.
- ACC_W, 2*DATA_W+clog2(N_IN), accumulator width; overflow-free by construction.
- OUT_W, 16, result width.

Ports:
- Clk  in  1  clock; all logic on rising edge.
- Rst  in  1  reset; synchronous, active-high.
- In_Valid  in  1  beat valid.
- In_Ready  out  1  engine accepts beat.
- In_Data  in  LANES*DATA_W  pixels; lane k at bits [k*DATA_W +: DATA_W].
- W_Data  in  N_FILT*LANES*DATA_W  weights; filter f, lane k at [(f*LANES+k)*DATA_W +: DATA_W].
- Mode  in  1  0 = max pool, 1 = average pool; sampled on first accepted beat of a window.
- Out_Valid  out  1  result valid.
- Out_Ready  in  1  downstream accepts result.
- Out_Data  out  OUT_W  pooled result, saturated.
- Out_Idx  out  clog2(N_FILT)  winning filter (max mode); 0 in average mode.
- Out_Sat  out  1  result was clipped to 2^OUT_W-1.

## Operation

- States: ACC, POOL, OUT. Reset state ACC.
- ACC:
  - In_Ready=1.
  - On each In_Valid&&In_Ready, acc[f] += sum over lanes of In_Data[k]*W_Data[f][k] for every filter f.
  - Beat counter increments 0..BEATS-1.
  - Accepting the beat with counter = BEATS-1 → POOL; counter wraps to 0.
  - Cycles with In_Valid=0 change nothing.
- POOL: In_Ready=0, one cycle.
  - Max mode: select the largest acc[f]; ties resolve to the lowest index.
  - Average mode: (sum of all acc[f]) >> clog2(N_FILT), truncating. Sum width is ACC_W+clog2(N_FILT), no overflow.
  - If the selected value exceeds 2^OUT_W-1: Out_Data = all ones, Out_Sat=1. Otherwise Out_Data = value, Out_Sat=0.
  - Register Out_Data, Out_Idx, Out_Sat → OUT.
- OUT:
  - Out_Valid=1, In_Ready=0.
  - Outputs held stable until Out_Valid&&Out_Ready.
  - On handshake: clear all acc[f] and the latched mode → ACC.
  - In_Valid beats presented in POOL/OUT are not accepted; the upstream must hold them.
- Mode latch: the mode captured on beat 0 governs the whole window; later changes of the Mode pin within the window are ignored.
- Rst at any point (mid-window included): partial accumulation discarded, counter=0, state ACC.

## Timing

- Reset values: In_Ready=1 (first cycle after Rst deasserts), Out_Valid=0, Out_Data=0, Out_Idx=0, Out_Sat=0; all accumulators 0.
- Multiply-accumulate is single-cycle: an accepted beat updates acc on the same edge.
- Latency:
  - Last beat accepted at edge t → POOL during cycle t+1.
  - Out_Valid=1 from edge t+2.
- Out handshake at edge u → Out_Valid=0 and In_Ready=1 from edge u+1.
- Minimum period per window: BEATS+2 cycles, with continuous In_Valid and Out_Ready=1. Default is 6.
- No combinational path from Out_Ready or In_Valid to any output; In_Ready and Out_Valid are decoded from registered state.

## Test plan

Defaults apply: N_IN=16, LANES=4, N_FILT=4, so BEATS=4.

1. Max mode: all pixels 1, filter f weights f+1, four back-to-back beats → Out_Valid 2 cycles after last beat; Out_Data=64, Out_Idx=3, Out_Sat=0.
2. Average mode, same data → Out_Data=(16+32+48+64)/4=40, Out_Idx=0. All weights equal 2 in max mode → Out_Data=32, Out_Idx=0 (tie to lowest index).
3. Saturation: pixels 255, filter 0 weights 255, others 0, max mode → acc0=1040400; Out_Data=0xFFFF, Out_Sat=1, Out_Idx=0.
4. Backpressure: hold Out_Ready=0 for 5 cycles with In_Valid=1 → In_Ready=0 and outputs frozen throughout. The beat after the handshake starts a new window; its result is computed from fresh (cleared) accumulators.
5. Bubbles: In_Valid toggled 1,0,0,1,1,0,1 with data of case 1 → identical result to case 1. Mode pin flipped mid-window → result follows the mode captured on beat 0.
6. Rst asserted after 2 beats → next cycle all outputs at reset values. A following full case-1 window yields 64 (no residue from the partial window).
